// File: rtl/sum_accum.sv
`default_nettype none
// ============================================================================
// Module  : sum_accum
// Brief   : Multi-lane group accumulator. Each output is the lane-wise sum of
//           NBEATS accepted input beats. Lanes can be signed or unsigned, and
//           can saturate or wrap. Each lane has a sticky overflow flag. The
//           output uses a valid/ready handshake and has one cycle of latency.
// Revision: 1.0 - initial release
// ============================================================================
module sum_accum #(
  parameter int WIDTH    = 32,
  parameter int LANES    = 4,
  parameter int NBEATS   = 4,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WIDTH-1:0]        in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*WIDTH-1:0]        out_data,
  output logic [LANES-1:0]              out_ovf,
  output logic [$clog2(NBEATS+1)-1:0]   beat_cnt
);

  localparam int              CW        = $clog2(NBEATS+1);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(NBEATS-1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                   state;
  logic [LANES*WIDTH-1:0]   acc;
  logic [LANES-1:0]         flags;
  logic [LANES*WIDTH-1:0]   lane_sum;
  logic [LANES-1:0]         lane_ovf;
  logic                     accept;
  logic                     last_beat;
  logic                     handshake;

  // A held result blocks input unless it drains on this edge. clear always
  // blocks input, so it takes priority over a beat offered at the same time.
  assign in_ready  = !clear && ((state == ACC) || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (beat_cnt == LAST_BEAT);
  assign handshake = out_valid && out_ready;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH:0]   sum;
      logic             ovf;

      assign a = acc[l*WIDTH +: WIDTH];
      assign b = in_data[l*WIDTH +: WIDTH];

      // Add in WIDTH+1 bits. The extra bit shows whether the result left the
      // representable range.
      if (SIGNED != 0) begin : g_signed
        assign sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        assign ovf = sum[WIDTH] ^ sum[WIDTH-1];
      end else begin : g_unsigned
        assign sum = {1'b0, a} + {1'b0, b};
        assign ovf = sum[WIDTH];
      end

      assign lane_ovf[l] = ovf;

      if (SATURATE != 0) begin : g_sat
        logic [WIDTH-1:0] limit;
        if (SIGNED != 0) begin : g_slim
          // The sign of the true sum selects the rail that was crossed.
          assign limit = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin : g_ulim
          assign limit = {WIDTH{1'b1}};
        end
        assign lane_sum[l*WIDTH +: WIDTH] = ovf ? limit : sum[WIDTH-1:0];
      end else begin : g_wrap
        assign lane_sum[l*WIDTH +: WIDTH] = sum[WIDTH-1:0];
      end
    end
  endgenerate

  // Control FSM, accumulators and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      flags     <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= '0;
    end else begin
      // Draining the held result returns to ACC. A group that completes on
      // the same edge overrides this below and keeps out_valid high.
      if (handshake) begin
        out_valid <= 1'b0;
        state     <= ACC;
      end

      if (clear) begin
        acc      <= '0;
        flags    <= '0;
        beat_cnt <= '0;
      end else if (last_beat) begin
        out_data  <= lane_sum;
        out_ovf   <= flags | lane_ovf;
        out_valid <= 1'b1;
        state     <= HOLD;
        acc       <= '0;
        flags     <= '0;
        beat_cnt  <= '0;
      end else if (accept) begin
        acc      <= lane_sum;
        flags    <= flags | lane_ovf;
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_sum_accum
// Brief   : Scoreboard bench for sum_accum. Three instances (signed/saturate,
//           signed/wrap, unsigned/saturate) share one stimulus stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sum_accum;

  localparam int W    = 8;
  localparam int L    = 2;
  localparam int NB   = 3;
  localparam int NCFG = 3;

  typedef struct packed {
    logic [L*W-1:0] data;
    logic [L-1:0]   ovf;
  } grp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic           in_valid;
  logic           out_ready;
  logic [L*W-1:0] in_data;

  logic           in_ready  [NCFG];
  logic           out_valid [NCFG];
  logic [L*W-1:0] out_data  [NCFG];
  logic [L-1:0]   out_ovf   [NCFG];
  logic [1:0]     beat_cnt  [NCFG];

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  grp_t q0[$];
  grp_t q1[$];
  grp_t q2[$];

  // Reference model state: per-lane values are plain integers.
  bit m_hold;
  int m_cnt;
  int m_acc [NCFG][L];
  bit m_flg [NCFG][L];

  always #5 clk = ~clk;

  sum_accum #(.WIDTH(W), .LANES(L), .NBEATS(NB), .SIGNED(1), .SATURATE(1)) u_ss (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_data(out_data[0]), .out_ovf(out_ovf[0]), .beat_cnt(beat_cnt[0]));

  sum_accum #(.WIDTH(W), .LANES(L), .NBEATS(NB), .SIGNED(1), .SATURATE(0)) u_sw (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_data(out_data[1]), .out_ovf(out_ovf[1]), .beat_cnt(beat_cnt[1]));

  sum_accum #(.WIDTH(W), .LANES(L), .NBEATS(NB), .SIGNED(0), .SATURATE(1)) u_us (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_data(out_data[2]), .out_ovf(out_ovf[2]), .beat_cnt(beat_cnt[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] pk(input int a, input int b);
    return {b[7:0], a[7:0]};
  endfunction

  // cfg 0: signed saturate, 1: signed wrap, 2: unsigned saturate
  function automatic void lane_add(input int cfg, input int a, input int x_raw,
                                   output int r, output bit o);
    int x, s, lo, hi;
    if (cfg == 2) begin
      x = x_raw; lo = 0; hi = 255;
    end else begin
      x = (x_raw >= 128) ? x_raw - 256 : x_raw; lo = -128; hi = 127;
    end
    s = a + x;
    o = (s < lo) || (s > hi);
    if (!o) r = s;
    else if (cfg == 1) begin
      r = s & 255;
      if (r >= 128) r = r - 256;
    end else r = (s > hi) ? hi : lo;
  endfunction

  task automatic push(input int k, input grp_t g);
    case (k)
      0: q0.push_back(g);
      1: q1.push_back(g);
      default: q2.push_back(g);
    endcase
  endtask

  task automatic pop(input int k, output grp_t g, output bit ok);
    g = '0; ok = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin g = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin g = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin g = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic model_zero();
    for (int k = 0; k < NCFG; k++)
      for (int l = 0; l < L; l++) begin
        m_acc[k][l] = 0; m_flg[k][l] = 1'b0;
      end
    m_cnt = 0;
  endtask

  // Apply the block's rules for one clock edge using the inputs that were driven.
  task automatic model_edge(input bit iv, input logic [15:0] d, input bit ordy, input bit clr);
    bit   rdy, acpt, o;
    int   r;
    grp_t g;
    rdy  = !clr && (!m_hold || ordy);
    acpt = iv && rdy;
    if (m_hold && ordy) m_hold = 1'b0;
    if (clr) model_zero();
    else if (acpt) begin
      for (int k = 0; k < NCFG; k++)
        for (int l = 0; l < L; l++) begin
          lane_add(k, m_acc[k][l], int'(d[l*W +: W]), r, o);
          m_acc[k][l] = r;
          m_flg[k][l] = m_flg[k][l] | o;
        end
      if (m_cnt == NB - 1) begin
        for (int k = 0; k < NCFG; k++) begin
          g = '0;
          for (int l = 0; l < L; l++) begin
            g.data[l*W +: W] = W'(m_acc[k][l] & 255);
            g.ovf[l]         = m_flg[k][l];
          end
          push(k, g);
        end
        model_zero();
        m_hold = 1'b1;
      end else m_cnt++;
    end
  endtask

  // Called at posedge+1. Drives inputs, checks combinational/state outputs,
  // then crosses one edge.
  task automatic step(input bit iv, input logic [15:0] d, input bit ordy, input bit clr);
    in_valid = iv; in_data = d; out_ready = ordy; clear = clr;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      chk("in_ready", 32'(in_ready[k]), 32'(!clr && (!m_hold || ordy)));
      chk("out_valid", 32'(out_valid[k]), 32'(m_hold));
      chk("beat_cnt", 32'(beat_cnt[k]), 32'(m_cnt));
    end
    @(posedge clk);
    model_edge(iv, d, ordy, clr);
    #1;
  endtask

  // Asserted between edges: outputs must clear without any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_beat_cnt", 32'(beat_cnt[k]), 32'd0);
    end
    q0.delete(); q1.delete(); q2.delete();
    m_hold = 1'b0;
    model_zero();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: a presented group is consumed when out_ready is high.
  always @(negedge clk) begin : mon
    grp_t g;
    bit   ok;
    for (int k = 0; k < NCFG; k++) begin
      if (!rst && out_valid[k] && out_ready) begin
        pop(k, g, ok);
        if (!ok) begin
          checks++; failures++;
          $display("FAIL sb_unexpected dut=%0d actual=%0h required=none", k, out_data[k]);
        end else begin
          chk("sb_data", 32'(out_data[k]), 32'(g.data));
          chk("sb_ovf", 32'(out_ovf[k]), 32'(g.ovf));
        end
        if (k == 0) pops++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] held;
    int          p0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    m_hold = 1'b0;
    model_zero();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NCFG; k++) begin
      chk("reset_valid", 32'(out_valid[k]), 32'd0);
      chk("reset_data", 32'(out_data[k]), 32'd0);
      chk("reset_ovf", 32'(out_ovf[k]), 32'd0);
      chk("reset_cnt", 32'(beat_cnt[k]), 32'd0);
    end
    rst = 1'b0;

    // Reset mid-group, then reset while holding a result.
    step(1, pk(5, 7), 1, 0);
    step(1, pk(9, 3), 1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, pk(40, 41), 0, 0);
    step(0, 16'h0, 0, 0);
    do_reset();
    for (int i = 1; i <= 3; i++) step(1, pk(i, 0), 1, 0);
    chk("reset_sum_l0", 32'(out_data[0][7:0]), 32'd6);
    chk("reset_sum_ovf", 32'(out_ovf[0]), 32'd0);
    step(0, 16'h0, 1, 0);

    // Signed saturate and wrap.
    step(1, pk(100, 0), 1, 0);
    step(1, pk(100, 0), 1, 0);
    step(1, pk(-50, 0), 1, 0);
    chk("ssat_l0", 32'(out_data[0][7:0]), 32'd77);
    chk("ssat_ovf", 32'(out_ovf[0][0]), 32'd1);
    chk("swrap_l0", 32'(out_data[1][7:0]), 32'h96);
    chk("swrap_ovf", 32'(out_ovf[1][0]), 32'd1);
    step(0, 16'h0, 1, 0);

    // Unsigned saturate.
    step(1, pk(1, 200), 1, 0);
    step(1, pk(1, 100), 1, 0);
    step(1, pk(1, 10), 1, 0);
    chk("usat_l1", 32'(out_data[2][15:8]), 32'd255);
    chk("usat_l0", 32'(out_data[2][7:0]), 32'd3);
    chk("usat_ovf", 32'(out_ovf[2]), 32'b10);
    step(0, 16'h0, 1, 0);

    // Backpressure.
    for (int i = 0; i < 3; i++) step(1, pk(10 + i, 20 + i), 0, 0);
    held = out_data[0];
    for (int i = 0; i < 5; i++) begin
      step(1, pk(99, 99), 0, 0);
      chk("bp_stable", 32'(out_data[0]), 32'(held));
    end
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0);

    // Throughput: 12 beats, 4 groups.
    p0 = pops;
    for (int i = 1; i <= 12; i++) step(1, pk(i, 100 + i), 1, 0);
    step(0, 16'h0, 1, 0);
    chk("thru_groups", 32'(pops - p0), 32'd4);

    // Clear mid-group (with a competing beat), then clear while holding.
    step(1, pk(50, 60), 1, 0);
    step(1, pk(50, 60), 1, 0);
    step(1, pk(77, 77), 1, 1);
    for (int i = 1; i <= 3; i++) step(1, pk(i, i), 0, 0);
    chk("clear_sum", 32'(out_data[0][7:0]), 32'd6);
    held = out_data[0];
    step(1, pk(5, 5), 0, 1);
    step(1, pk(5, 5), 0, 1);
    chk("clear_hold", 32'(out_data[0]), 32'(held));
    step(0, 16'h0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
    repeat (4) step(0, 16'h0, 1, 0);
    chk("sb_drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, lane data width in bits (>=2).
REQ-002 The block SHALL have parameter LANES, default 4, number of independent accumulation lanes (>=1).
REQ-003 The block SHALL have parameter NBEATS, default 4, input beats summed per output group (>=1).
REQ-004 The block SHALL have parameter SIGNED, default 1: 1 = two's-complement lanes, 0 = unsigned lanes.
REQ-005 The block SHALL have parameter SATURATE, default 1: 1 = clamp on overflow, 0 = wrap modulo 2^WIDTH.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous discard of the partial group.
REQ-009 The block SHALL have port in_valid, input, 1 bit: an input beat is offered.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered beat.
REQ-011 The block SHALL have port in_data, input, LANES*WIDTH bits: lane l is bits [l*WIDTH +: WIDTH].
REQ-012 The block SHALL have port out_valid, output, 1 bit: a completed group sum is presented.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer takes the presented group.
REQ-014 The block SHALL have port out_data, output, LANES*WIDTH bits: per-lane group sums, same packing as in_data.
REQ-015 The block SHALL have port out_ovf, output, LANES bits: per-lane sticky overflow flag for the presented group.
REQ-016 The block SHALL have port beat_cnt, output, clog2(NBEATS+1) bits: beats accepted in the current partial group.

Function
REQ-017 The block SHALL implement two states: ACC (collecting beats) and HOLD (presenting a result).
REQ-018 A beat SHALL be accepted on any rising edge where in_valid && in_ready.
REQ-019 in_ready SHALL be: ACC -> !clear; HOLD -> out_ready && !clear.
REQ-020 On each accepted beat, every lane SHALL compute acc[l] + in_data lane l in WIDTH+1 bits, interpreted per SIGNED.
REQ-021 On out-of-range results: SATURATE=1 clamps to 2^(W-1)-1 / -2^(W-1) when signed and to 2^W-1 when unsigned; SATURATE=0 keeps the low WIDTH bits.
REQ-022 Any lane overflow within a group SHALL set that lane's sticky flag regardless of SATURATE.
REQ-023 When the accepted beat is beat NBEATS of the group, the block SHALL load out_data and out_ovf with the final lane sums and flags, set out_valid the next cycle, clear acc, flags and beat_cnt, and enter HOLD.
REQ-024 Latency SHALL be one cycle: out_valid rises on the edge that accepts the last beat.
REQ-025 In HOLD, out_data, out_ovf and out_valid SHALL remain stable until out_valid && out_ready.
REQ-026 On an out_valid && out_ready edge with no new group completing, the block SHALL drop out_valid and enter ACC.
REQ-027 A beat accepted on the same edge as the output handshake SHALL count as beat 1 of the new group; with NBEATS=1 it SHALL directly become the new output, keeping out_valid high.
REQ-028 For steady in_valid=1 and out_ready=1, the block SHALL produce one group per NBEATS cycles with no lost or duplicated beats.
REQ-029 clear SHALL zero acc, flags and beat_cnt on the next edge, SHALL NOT affect a held output, and SHALL win over a simultaneous beat, because in_ready is low.
REQ-030 beat_cnt SHALL count 0..NBEATS-1 and wrap to 0 on group completion.

Reset
REQ-031 While rst is high, the block SHALL immediately force out_valid=0, out_data=0, out_ovf=0, beat_cnt=0, all accumulators and flags to 0, and state to ACC, independent of clk.
REQ-032 After rst deasserts, in_ready SHALL be 1 (when clear=0), and the first accepted beat SHALL start a new group.
REQ-033 A reset during HOLD or mid-group SHALL discard all data with no output emitted.

Verification (WIDTH=8, LANES=2, NBEATS=3 unless stated)
REQ-034 Reset check: assert rst mid-group -> out_valid=0, beat_cnt=0 asynchronously; after release, beats 1,2,3 on lane0 -> out_data lane0=6, ovf=0.
REQ-035 Signed saturate: lane0 beats 100,100,-50 -> SATURATE=1 gives 77 with ovf=1; SATURATE=0 gives -106 with ovf=1.
REQ-036 Unsigned saturate: SIGNED=0, lane1 beats 200,100,10 -> 255 with ovf[1]=1; lane0 beats 1,1,1 -> 3 with ovf[0]=0.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles after a group completes -> out_data stable, in_ready=0; after the handshake, state returns to ACC.
REQ-038 Throughput: in_valid=1 and out_ready=1 continuously for 12 cycles with counting data -> exactly 4 outputs, each the sum of 3 consecutive beats.
REQ-039 Clear: clear after 2 beats, then beats 1,2,3 -> output 6; clear asserted during HOLD -> held output unchanged.
